// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one shift-and-add step per cycle,
// built on a ripple parallel adder, with valid/ready handshakes on both sides.

module ripple_parallel_adder #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]     = x[i] ^ y[i] ^ carry[i];
            carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
        end
        cout = carry[WIDTH];
    end
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   s;
    logic               c;
    logic [2*WIDTH-1:0] shifted;

    assign addend = lo[0] ? mcand : '0;

    ripple_parallel_adder #(.WIDTH(WIDTH)) u_adder (
        .x    (hi),
        .y    (addend),
        .cin  (1'b0),
        .sum  (s),
        .cout (c)
    );

    // {c,s,lo} >> 1: the adder carry becomes the new top bit, so nothing is lost.
    assign shifted = {c, s, lo[WIDTH-1:1]};

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        lo    <= b;
                        hi    <= '0;
                        count <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    hi    <= shifted[2*WIDTH-1:WIDTH];
                    lo    <= shifted[WIDTH-1:0];
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        product <= shifted;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and exhaustive self-checking bench for shift_add_multiplier (WIDTH=3).

module tb_shift_add_multiplier;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] a;
    logic [2:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] product;
    logic       busy;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(.WIDTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        step(); step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (product !== 6'd0) begin errors++; $display("FAIL rst_product got=%0d exp=0", product); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
        step();
    endtask

    task automatic test_basic();
        a = 3'd7; b = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_calc busy=%b in_ready=%b exp=1/0", busy, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_e1 out_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_e2 out_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_e3 out_valid got=%b exp=1", out_valid); end
        checks++; if (product !== 6'd49) begin errors++; $display("FAIL basic_product got=%0d exp=49", product); end
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_vectors();
        logic [2:0] va [3] = '{3'd5, 3'd0, 3'd4};
        logic [2:0] vb [3] = '{3'd3, 3'd6, 3'd0};
        logic [5:0] ve [3] = '{6'd15, 6'd0, 6'd0};
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = va[i]; b = vb[i]; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 10) begin step(); n++; end
            checks++; if (n != 3) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=3", i, n); end
            checks++; if (product !== ve[i]) begin errors++; $display("FAIL vec%0d_product got=%0d exp=%0d", i, product, ve[i]); end
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_one_cycle out_valid got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        a = 3'd6; b = 3'd5; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || product !== 6'd30 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d out_valid=%b product=%0d in_ready=%b exp=1/30/0", i, out_valid, product, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_ignore_input();
        a = 3'd3; b = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
        step();
        a = 3'd7; b = 3'd7;
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ign_in_ready got=%b exp=0", in_ready); end
        step(); step();
        checks++; if (out_valid !== 1'b1 || product !== 6'd6) begin errors++; $display("FAIL ign_product valid=%b got=%0d exp=6", out_valid, product); end
        step();
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ign_no_same_cycle busy=%b in_ready=%b exp=0/1", busy, in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_accept_after_idle busy=%b exp=1", busy); end
        step(); step(); step();
        checks++; if (out_valid !== 1'b1 || product !== 6'd49) begin errors++; $display("FAIL ign_second valid=%b got=%0d exp=49", out_valid, product); end
        step();
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        a = 3'd7; b = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || product !== 6'd0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_state busy=%b valid=%b product=%0d in_ready=%b exp=0/0/0/0", busy, out_valid, product, in_ready);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen++;
            step();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_valid got=%0d cycles exp=0", seen); end
        a = 3'd2; b = 3'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        checks++; if (out_valid !== 1'b1 || product !== 6'd6) begin errors++; $display("FAIL midrst_next valid=%b got=%0d exp=6", out_valid, product); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_tab [64];
        logic [5:0] ia;
        int idx = 0, got = 0, cyc = 0;
        logic acc, del;
        for (int k = 0; k < 64; k++) exp_tab[k] = 6'((k >> 3) * (k & 7));
        ia = 6'(idx); a = ia[5:3]; b = ia[2:0]; in_valid = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        while (got < 64 && cyc < 3000) begin
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (del) begin
                checks++;
                if (product !== exp_tab[got]) begin errors++; $display("FAIL b2b_%0d got=%0d exp=%0d", got, product, exp_tab[got]); end
                got++;
            end
            step();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 64) begin ia = 6'(idx); a = ia[5:3]; b = ia[2:0]; end
                else in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        checks++; if (got != 64 || idx != 64) begin errors++; $display("FAIL b2b_count delivered=%0d accepted=%0d exp=64/64", got, idx); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_ignore_input();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
